// File: rtl/ir_cmd_queue.sv
// ir_cmd_queue: captures NEC frames from the IR receiver, checks integrity,
// tags key-hold repeats and queues accepted commands behind valid/ready.
// Optional build macro IR_ADDR_CHECK_EN: when defined, the address must also
// match its inverted copy (standard NEC). When undefined, address_bar is
// ignored so extended 16-bit addresses are accepted.
module ir_cmd_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int FREQ_MHz   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_MS    = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_address_bar,
  input  logic [DATA_WIDTH-1:0] i_command,
  input  logic [DATA_WIDTH-1:0] i_command_bar,
  input  logic                  i_valid,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [DATA_WIDTH-1:0] o_cmd,
  output logic [DATA_WIDTH-1:0] o_cmd_addr,
  output logic                  o_cmd_repeat,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [7:0]            o_err_cnt,
  output logic [7:0]            o_drop_cnt,
  output logic                  o_err_pulse
);

  localparam int HOLD_TICKS = HOLD_MS * 1000 * FREQ_MHz;
  localparam int HW         = $clog2(HOLD_TICKS + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int PW         = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] cmd;
    logic                  rpt;
  } entry_t;

  entry_t                mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  valid_q;
  logic                  armed;
  logic                  last_vld;
  logic [DATA_WIDTH-1:0] last_addr, last_cmd;
  logic [HW-1:0]         hold_cnt;
  logic                  frame_ev, frame_ok, is_repeat, push, pop;

`ifndef IR_ADDR_CHECK_EN
  // Address complement is deliberately ignored in extended-NEC builds.
  logic unused_addr_bar;
  assign unused_addr_bar = ^i_address_bar;
`endif

  // Frame event, integrity verdict, repeat detection and FIFO handshakes.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first so no latch can be inferred.
    frame_ev  = armed & i_valid & ~valid_q;
`ifdef IR_ADDR_CHECK_EN
    frame_ok  = (i_command_bar == ~i_command) && (i_address_bar == ~i_address);
`else
    frame_ok  = (i_command_bar == ~i_command);
`endif
    is_repeat = last_vld && (i_address == last_addr) && (i_command == last_cmd)
                && (hold_cnt != '0);
    push      = frame_ev & frame_ok & ~o_full;
    pop       = o_cmd_valid & i_cmd_ready;
  end

  // Queue status and show-ahead head entry.
  always_comb begin
    o_empty      = (wr_ptr == rd_ptr);
    o_full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    o_cmd_valid  = ~o_empty;
    o_cmd        = mem[rd_ptr[AW-1:0]].cmd;
    o_cmd_addr   = mem[rd_ptr[AW-1:0]].addr;
    o_cmd_repeat = mem[rd_ptr[AW-1:0]].rpt;
  end

  // Edge detector; 'armed' swallows the first cycle after reset so a level
  // that is already high at release does not look like a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking '<=' only.
    if (!rst_n) begin
      valid_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      valid_q <= i_valid;
      armed   <= 1'b1;
    end
  end

  // Repeat-tracking state and key-hold timer; a load beats the countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld  <= 1'b0;
      last_addr <= '0;
      last_cmd  <= '0;
      hold_cnt  <= '0;
    end else if (frame_ev && frame_ok) begin
      last_vld  <= 1'b1;
      last_addr <= i_address;
      last_cmd  <= i_command;
      hold_cnt  <= HW'(HOLD_TICKS);
    end else if (hold_cnt != '0) begin
      hold_cnt  <= hold_cnt - HW'(1);
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; pointers define which entries are live.
    if (push) mem[wr_ptr[AW-1:0]] <= '{addr: i_address, cmd: i_command, rpt: is_repeat};
  end

  // Read/write pointers with wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Saturating error/drop counters and the error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err_cnt   <= 8'd0;
      o_drop_cnt  <= 8'd0;
      o_err_pulse <= 1'b0;
    end else begin
      o_err_pulse <= frame_ev & ~frame_ok;
      if (frame_ev && !frame_ok && o_err_cnt != 8'hFF)
        o_err_cnt <= o_err_cnt + 8'd1;
      if (frame_ev && frame_ok && o_full && o_drop_cnt != 8'hFF)
        o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ir_cmd_queue.sv
// Directed bench for ir_cmd_queue (short 1 ms hold window at 1 MHz).
module tb_ir_cmd_queue;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] i_address, i_address_bar, i_command, i_command_bar;
  logic          i_valid, i_cmd_ready;
  logic          o_cmd_valid, o_cmd_repeat, o_full, o_empty, o_err_pulse;
  logic [DW-1:0] o_cmd, o_cmd_addr;
  logic [7:0]    o_err_cnt, o_drop_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  ir_cmd_queue #(.DATA_WIDTH(DW), .FREQ_MHz(1), .FIFO_DEPTH(4), .HOLD_MS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_address_bar(i_address_bar),
    .i_command(i_command), .i_command_bar(i_command_bar),
    .i_valid(i_valid),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd(o_cmd), .o_cmd_addr(o_cmd_addr), .o_cmd_repeat(o_cmd_repeat),
    .o_full(o_full), .o_empty(o_empty),
    .o_err_cnt(o_err_cnt), .o_drop_cnt(o_drop_cnt), .o_err_pulse(o_err_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle frame: driven at a falling edge, sampled at the next rising
  // edge, i_valid dropped at the following falling edge (where checks run).
  task automatic send_frame(input logic [DW-1:0] a, ab, c, cb);
    @(negedge clk);
    i_address = a; i_address_bar = ab; i_command = c; i_command_bar = cb;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_cmd_ready = 1'b0;
    i_address = '0; i_address_bar = '0; i_command = '0; i_command_bar = '0;

    // Reset state
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_empty", o_empty, 1);
    check("rst_valid", o_cmd_valid, 0);
    check("rst_full", o_full, 0);
    check("rst_err", o_err_cnt, 0);
    check("rst_drop", o_drop_cnt, 0);
    check("rst_pulse", o_err_pulse, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single good frame, consumer ready: visible for exactly one cycle
    i_cmd_ready = 1'b1;
    send_frame(8'd46, ~8'd46, 8'd13, ~8'd13);
    check("one_valid", o_cmd_valid, 1);
    check("one_cmd", o_cmd, 13);
    check("one_addr", o_cmd_addr, 46);
    check("one_rpt", o_cmd_repeat, 0);
    @(negedge clk);
    check("one_empty", o_empty, 1);

    // Integrity failure
    send_frame(8'd46, ~8'd46, 8'd25, 8'd25);
    exp_err++;
    check("bad_pulse", o_err_pulse, 1);
    check("bad_errcnt", o_err_cnt, exp_err);
    check("bad_empty", o_empty, 1);
    @(negedge clk);
    check("bad_pulse_off", o_err_pulse, 0);

    // Fill queue with 5 frames while consumer stalls; fifth is dropped
    i_cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(8'd7, ~8'd7, DW'(k), ~DW'(k));
    check("fill_full", o_full, 1);
    check("fill_drop", o_drop_cnt, 1);
    check("fill_head", o_cmd, 1);
    check("fill_rpt", o_cmd_repeat, 0);
    @(negedge clk);
    // Push while full with same-cycle pop: push dropped, pop happens
    i_cmd_ready = 1'b1;
    i_address = 8'd7; i_address_bar = ~8'd7; i_command = 8'd6; i_command_bar = ~8'd6;
    i_valid = 1'b1;
    check("drain_1", o_cmd, 1);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("fullpop_drop", o_drop_cnt, 2);
    check("fullpop_full", o_full, 0);
    check("drain_2", o_cmd, 2);
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("drain_%0d", k), o_cmd, k);
    end
    @(negedge clk);
    check("drain_empty", o_empty, 1);

    // Key-hold window of 1000 cycles: repeat flags 0, 1, 0
    send_frame(8'd22, ~8'd22, 8'd25, ~8'd25);
    check("hold0_valid", o_cmd_valid, 1);
    check("hold0_rpt", o_cmd_repeat, 0);
    repeat (495) @(posedge clk);
    send_frame(8'd22, ~8'd22, 8'd25, ~8'd25);
    check("hold1_valid", o_cmd_valid, 1);
    check("hold1_rpt", o_cmd_repeat, 1);
    repeat (1500) @(posedge clk);
    send_frame(8'd22, ~8'd22, 8'd25, ~8'd25);
    check("hold2_valid", o_cmd_valid, 1);
    check("hold2_rpt", o_cmd_repeat, 0);
    @(negedge clk);

    // Level-high i_valid for several cycles gives exactly one entry
    i_cmd_ready = 1'b0;
    i_address = 8'd3; i_address_bar = ~8'd3; i_command = 8'd9; i_command_bar = ~8'd9;
    i_valid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("level_valid", o_cmd_valid, 1);
    check("level_cmd", o_cmd, 9);
    i_cmd_ready = 1'b1;
    @(negedge clk);
    check("level_single", o_empty, 1);

    // Mismatched address complement
    send_frame(8'd46, 8'd33, 8'd13, ~8'd13);
`ifdef IR_ADDR_CHECK_EN
    exp_err++;
    check("abar_err", o_err_cnt, exp_err);
    check("abar_empty", o_empty, 1);
`else
    check("abar_valid", o_cmd_valid, 1);
    check("abar_cmd", o_cmd, 13);
    check("abar_rpt", o_cmd_repeat, 0);
    check("abar_err", o_err_cnt, exp_err);
`endif
    @(negedge clk);

    // Error counter saturation
    for (int k = 0; k < 260; k++) send_frame(8'd1, ~8'd1, 8'd2, 8'd2);
    check("err_sat", o_err_cnt, 255);

    // Asynchronous reset mid-operation with i_valid held high
    i_cmd_ready = 1'b0;
    @(negedge clk);
    i_address = 8'd50; i_address_bar = ~8'd50; i_command = 8'd60; i_command_bar = ~8'd60;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_valid", o_cmd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_err", o_err_cnt, 0);
    check("mid_rst_drop", o_drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rel_no_event", o_empty, 1);
    i_valid = 1'b0;
    @(negedge clk);
    send_frame(8'd50, ~8'd50, 8'd60, ~8'd60);
    check("rel_resync", o_cmd_valid, 1);
    check("rel_cmd", o_cmd, 60);
    check("rel_rpt", o_cmd_repeat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
